// File: rtl/ddr3_cmd_scheduler.sv
// ddr3_cmd_scheduler
// Open-row command scheduler in front of a DDR3 command state machine.
// Two requesters are arbitrated round-robin. A hit on the open row issues
// READ/WRITE with tCCD spacing. A miss precharges all banks and then
// activates the new row. A periodic refresh (every tREFI cycles) pre-empts
// requests at every decision point.
//
// Ports:
//   CLK, RESET            : clock (rising edge) and synchronous active-high reset
//   req_valid/req_write   : per-requester valid and write(1)/read(0)
//   req_bank/row/col      : packed {r1, r0} addresses
//   req_ready             : one-cycle accept strobe, aligned with READ/WRITE
//   ACT/PRE/REF/WRITE/READ: one-cycle command pulses (mutually exclusive)
//   Addr_Row/Addr_Column  : row for ACT, column for READ/WRITE
//   BA_in                 : bank for ACT/READ/WRITE
//   A_10, A_12            : all-bank precharge flag, burst-length select
//   busy                  : high whenever the scheduler is not IDLE
//
// Every output is registered. The output and state registers are loaded
// together from the next-state decision. As a result, a command pulse is
// high during the cycle in which the FSM occupies the matching state.
module ddr3_cmd_scheduler #(
  parameter int tRCD  = 3,
  parameter int tRP   = 3,
  parameter int tRFC  = 10,
  parameter int tREFI = 100,
  parameter int tCCD  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [5:0]  req_bank,
  input  logic [29:0] req_row,
  input  logic [19:0] req_col,
  output logic [1:0]  req_ready,
  output logic        ACT,
  output logic        PRE,
  output logic        REF,
  output logic        WRITE,
  output logic        READ,
  output logic [14:0] Addr_Row,
  output logic [9:0]  Addr_Column,
  output logic [2:0]  BA_in,
  output logic        A_10,
  output logic        A_12,
  output logic        busy
);

  localparam int M1       = (tRCD > tRP) ? tRCD : tRP;
  localparam int M2       = (M1 > tRFC) ? M1 : tRFC;
  localparam int WAIT_MAX = (M2 > tCCD) ? M2 : tCCD;
  localparam int CW       = $clog2(WAIT_MAX + 1);
  localparam int TW       = $clog2(tREFI + 1);

  localparam logic [CW-1:0] RCD_LAST   = CW'(tRCD - 1);
  localparam logic [CW-1:0] RP_LAST    = CW'(tRP - 1);
  localparam logic [CW-1:0] RFC_LAST   = CW'(tRFC - 1);
  localparam logic [CW-1:0] CCD_LOAD   = CW'(tCCD - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(WAIT_MAX);
  localparam logic [TW-1:0] TREFI_LAST = TW'(tREFI - 1);

  typedef enum logic [2:0] {
    IDLE, ACTIVATE, ACT_WAIT, OPEN, PRECHARGE, PRE_WAIT, REFRESH, REF_WAIT
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] wait_cnt_r, ccd_cnt_r;
  logic [TW-1:0] refi_cnt_r;
  logic          ref_pending_r, open_r, prio_r;
  logic [2:0]    open_bank_r;
  logic [14:0]   open_row_r;

  logic [1:0]  avail_s, ready_s;
  logic        winner_s, w_write_s, hit_s, any_s;
  logic [2:0]  w_bank_s;
  logic [14:0] w_row_s;
  logic [9:0]  w_col_s;
  logic        idle_dec_s, open_dec_s;
  logic        act_s, pre_s, ref_s, wr_s, rd_s, a10_s, a12_s, open_s, prio_s;
  logic [14:0] row_s, orow_s;
  logic [9:0]  col_s;
  logic [2:0]  ba_s, obank_s;

  // Round-robin winner select. A requester being strobed this cycle is
  // already consumed, so it is masked out of the decision.
  always_comb begin
    avail_s = req_valid & ~req_ready;
    any_s   = |avail_s;
    if (avail_s == 2'b11) begin
      winner_s = prio_r;
    end else begin
      winner_s = avail_s[1];
    end
    w_bank_s  = winner_s ? req_bank[5:3]   : req_bank[2:0];
    w_row_s   = winner_s ? req_row[29:15]  : req_row[14:0];
    w_col_s   = winner_s ? req_col[19:10]  : req_col[9:0];
    w_write_s = winner_s ? req_write[1]    : req_write[0];
    hit_s     = open_r && (w_bank_s == open_bank_r) && (w_row_s == open_row_r);
  end

  // Next-state and next-output decision.
  always_comb begin
    state_s    = state_r;
    idle_dec_s = 1'b0;
    open_dec_s = 1'b0;
    act_s      = 1'b0;
    pre_s      = 1'b0;
    ref_s      = 1'b0;
    wr_s       = 1'b0;
    rd_s       = 1'b0;
    a10_s      = 1'b0;
    a12_s      = 1'b0;
    ready_s    = 2'b00;
    row_s      = Addr_Row;
    col_s      = Addr_Column;
    ba_s       = BA_in;
    open_s     = open_r;
    obank_s    = open_bank_r;
    orow_s     = open_row_r;
    prio_s     = prio_r;

    case (state_r)
      IDLE:      idle_dec_s = 1'b1;
      ACTIVATE:  state_s = ACT_WAIT;
      // The last wait cycle already decides the column command, so that the
      // command lands exactly tRCD cycles after ACT.
      ACT_WAIT: begin
        if (wait_cnt_r == RCD_LAST) begin
          open_dec_s = 1'b1;
        end else begin
          state_s = ACT_WAIT;
        end
      end
      OPEN:      open_dec_s = 1'b1;
      PRECHARGE: state_s = PRE_WAIT;
      PRE_WAIT: begin
        if (wait_cnt_r == RP_LAST) begin
          idle_dec_s = 1'b1;
        end else begin
          state_s = PRE_WAIT;
        end
      end
      REFRESH:   state_s = REF_WAIT;
      REF_WAIT: begin
        if (wait_cnt_r != RFC_LAST) begin
          state_s = REF_WAIT;
        end else if (ref_pending_r) begin
          state_s = REFRESH;
          ref_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default:   state_s = IDLE;
    endcase

    // With all banks closed, refresh first, otherwise open the winner's row.
    if (idle_dec_s) begin
      if (ref_pending_r) begin
        state_s = REFRESH;
        ref_s   = 1'b1;
      end else if (any_s) begin
        state_s = ACTIVATE;
        act_s   = 1'b1;
        row_s   = w_row_s;
        ba_s    = w_bank_s;
        open_s  = 1'b1;
        obank_s = w_bank_s;
        orow_s  = w_row_s;
      end else begin
        state_s = IDLE;
      end
    end else begin
      idle_dec_s = 1'b0;
    end

    // Row open: refresh or a miss closes it, and a hit issues a column command once tCCD allows.
    if (open_dec_s) begin
      if (ref_pending_r || (any_s && !hit_s)) begin
        state_s = PRECHARGE;
        pre_s   = 1'b1;
        a10_s   = 1'b1;
        open_s  = 1'b0;
      end else if (any_s && (ccd_cnt_r == {CW{1'b0}})) begin
        state_s           = OPEN;
        wr_s              = w_write_s;
        rd_s              = !w_write_s;
        col_s             = w_col_s;
        ba_s              = w_bank_s;
        a12_s             = 1'b1;
        ready_s[winner_s] = 1'b1;
        prio_s            = !winner_s;
      end else begin
        state_s = OPEN;
      end
    end else begin
      open_dec_s = 1'b0;
    end
  end

  // State, timers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r       <= IDLE;
      wait_cnt_r    <= {CW{1'b0}};
      ccd_cnt_r     <= {CW{1'b0}};
      refi_cnt_r    <= {TW{1'b0}};
      ref_pending_r <= 1'b0;
      open_r        <= 1'b0;
      open_bank_r   <= 3'd0;
      open_row_r    <= 15'd0;
      prio_r        <= 1'b0;
      req_ready     <= 2'b00;
      ACT           <= 1'b0;
      PRE           <= 1'b0;
      REF           <= 1'b0;
      WRITE         <= 1'b0;
      READ          <= 1'b0;
      Addr_Row      <= 15'd0;
      Addr_Column   <= 10'd0;
      BA_in         <= 3'd0;
      A_10          <= 1'b0;
      A_12          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_r     <= state_s;
      open_r      <= open_s;
      open_bank_r <= obank_s;
      open_row_r  <= orow_s;
      prio_r      <= prio_s;
      req_ready   <= ready_s;
      ACT         <= act_s;
      PRE         <= pre_s;
      REF         <= ref_s;
      WRITE       <= wr_s;
      READ        <= rd_s;
      Addr_Row    <= row_s;
      Addr_Column <= col_s;
      BA_in       <= ba_s;
      A_10        <= a10_s;
      A_12        <= a12_s;
      busy        <= (state_s != IDLE);

      // Counts cycles since the last ACT/PRE/REF pulse and saturates, so it never wraps inside a wait.
      if (act_s || pre_s || ref_s) begin
        wait_cnt_r <= {CW{1'b0}};
      end else if (wait_cnt_r != CNT_MAX) begin
        wait_cnt_r <= wait_cnt_r + CW'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end

      // A column command is allowed again when this counter reaches zero.
      if (wr_s || rd_s) begin
        ccd_cnt_r <= CCD_LOAD;
      end else if (ccd_cnt_r != {CW{1'b0}}) begin
        ccd_cnt_r <= ccd_cnt_r - CW'(1);
      end else begin
        ccd_cnt_r <= ccd_cnt_r;
      end

      // A wrap sets the request. If REF issues in the same cycle, the wrap still wins.
      if (refi_cnt_r == TREFI_LAST) begin
        refi_cnt_r    <= {TW{1'b0}};
        ref_pending_r <= 1'b1;
      end else begin
        refi_cnt_r    <= refi_cnt_r + TW'(1);
        ref_pending_r <= ref_pending_r && !ref_s;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_scheduler.sv
module tb_ddr3_cmd_scheduler;

  localparam int TREFI = 100;
  localparam int TRFC  = 10;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  req_valid, req_write;
  logic [5:0]  req_bank;
  logic [29:0] req_row;
  logic [19:0] req_col;
  logic [1:0]  req_ready;
  logic        ACT, PRE, REF, WRITE, READ;
  logic [14:0] Addr_Row;
  logic [9:0]  Addr_Column;
  logic [2:0]  BA_in;
  logic        A_10, A_12, busy;

  ddr3_cmd_scheduler #(.tRCD(3), .tRP(3), .tRFC(TRFC), .tREFI(TREFI), .tCCD(4)) dut (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_write(req_write),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .req_ready(req_ready), .ACT(ACT), .PRE(PRE), .REF(REF), .WRITE(WRITE),
    .READ(READ), .Addr_Row(Addr_Row), .Addr_Column(Addr_Column), .BA_in(BA_in),
    .A_10(A_10), .A_12(A_12), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0]  valid, write;
    logic [5:0]  bank;
    logic [29:0] row;
    logic [19:0] col;
    logic [4:0]  cmd;     // {ACT,PRE,REF,WRITE,READ}
    logic [1:0]  ready;
    logic        busy;
    logic [14:0] arow;
    logic [9:0]  acol;
    logic [2:0]  ba;
    logic        a10, a12;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] w, input logic [9:0] c0,
                              input logic [4:0] cmd, input logic [1:0] rdy, input logic bsy,
                              input logic [14:0] arow, input logic [9:0] acol,
                              input logic [2:0] ba, input logic a12);
    vec_t r;
    r.valid = v;  r.write = w;
    r.bank  = {3'd0, 3'd2};
    r.row   = {15'd0, 15'd5};
    r.col   = {10'd0, c0};
    r.cmd   = cmd; r.ready = rdy; r.busy = bsy;
    r.arow  = arow; r.acol = acol; r.ba = ba; r.a10 = 1'b0; r.a12 = a12;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Advance until any command pulse appears; dt = -1 if the budget expires.
  task automatic next_cmd(input int budget, output int dt, output logic [4:0] cmd);
    dt  = -1;
    cmd = 5'b0;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if ({ACT, PRE, REF, WRITE, READ} != 5'b0) begin
        dt  = k;
        cmd = {ACT, PRE, REF, WRITE, READ};
        break;
      end
    end
  endtask

  function automatic logic [37:0] outs();
    return {ACT, PRE, REF, WRITE, READ, req_ready, busy, Addr_Row, Addr_Column, BA_in, A_10, A_12};
  endfunction

  int dt;
  logic [4:0] cmd;

  initial begin
    // Scenario 1 (cycles 0-4) and scenario 2 (cycles 5-10): row 5, bank 2.
    tbl[0]  = mk(2'b01, 2'b01, 10'h010, 5'b00000, 2'b00, 1'b0, 15'd0, 10'h000, 3'd0, 1'b0);
    tbl[1]  = mk(2'b01, 2'b01, 10'h010, 5'b10000, 2'b00, 1'b1, 15'd5, 10'h000, 3'd2, 1'b0);
    tbl[2]  = mk(2'b01, 2'b01, 10'h010, 5'b00000, 2'b00, 1'b1, 15'd5, 10'h000, 3'd2, 1'b0);
    tbl[3]  = mk(2'b01, 2'b01, 10'h010, 5'b00000, 2'b00, 1'b1, 15'd5, 10'h000, 3'd2, 1'b0);
    tbl[4]  = mk(2'b01, 2'b01, 10'h010, 5'b00010, 2'b01, 1'b1, 15'd5, 10'h010, 3'd2, 1'b1);
    tbl[5]  = mk(2'b01, 2'b00, 10'h020, 5'b00000, 2'b00, 1'b1, 15'd5, 10'h010, 3'd2, 1'b0);
    tbl[6]  = mk(2'b01, 2'b00, 10'h020, 5'b00000, 2'b00, 1'b1, 15'd5, 10'h010, 3'd2, 1'b0);
    tbl[7]  = mk(2'b01, 2'b00, 10'h020, 5'b00000, 2'b00, 1'b1, 15'd5, 10'h010, 3'd2, 1'b0);
    tbl[8]  = mk(2'b01, 2'b00, 10'h020, 5'b00001, 2'b01, 1'b1, 15'd5, 10'h020, 3'd2, 1'b1);
    tbl[9]  = mk(2'b00, 2'b00, 10'h020, 5'b00000, 2'b00, 1'b1, 15'd5, 10'h020, 3'd2, 1'b0);
    tbl[10] = mk(2'b00, 2'b00, 10'h020, 5'b00000, 2'b00, 1'b1, 15'd5, 10'h020, 3'd2, 1'b0);

    RESET = 1'b1; req_valid = 2'b00; req_write = 2'b00;
    req_bank = 6'd0; req_row = 30'd0; req_col = 20'd0;
    tick();
    tick();
    RESET = 1'b0;
    cyc = 0;

    for (int i = 0; i < 11; i++) begin
      check($sformatf("vec%0d", i), 64'(outs()),
            64'({tbl[i].cmd, tbl[i].ready, tbl[i].busy, tbl[i].arow, tbl[i].acol,
                 tbl[i].ba, tbl[i].a10, tbl[i].a12}));
      req_valid = tbl[i].valid; req_write = tbl[i].write;
      req_bank  = tbl[i].bank;  req_row   = tbl[i].row; req_col = tbl[i].col;
      tick();
    end

    // Scenario 3: r1 misses (row 6) at cycle 11 -> PRE, ACT +3, READ +3.
    req_valid = 2'b10; req_write = 2'b00;
    req_bank  = {3'd2, 3'd0}; req_row = {15'd6, 15'd0}; req_col = {10'h030, 10'h000};
    next_cmd(20, dt, cmd);
    check("s3_pre_dt", 64'(dt), 64'(1));
    check("s3_pre", 64'({cmd, A_10}), 64'({5'b01000, 1'b1}));
    next_cmd(20, dt, cmd);
    check("s3_act", 64'({dt[7:0], cmd, Addr_Row, BA_in}), 64'({8'd3, 5'b10000, 15'd6, 3'd2}));
    next_cmd(20, dt, cmd);
    check("s3_read", 64'({dt[7:0], cmd, req_ready, Addr_Column}),
          64'({8'd3, 5'b00001, 2'b10, 10'h030}));

    // Scenario 4: both requesters continuously hit row 6 -> 01, 10, 01.
    req_valid = 2'b11; req_write = 2'b00;
    req_bank  = {3'd2, 3'd2}; req_row = {15'd6, 15'd6}; req_col = {10'h041, 10'h040};
    next_cmd(20, dt, cmd);
    check("s4_first", 64'({dt[7:0], cmd, req_ready, Addr_Column}),
          64'({8'd4, 5'b00001, 2'b01, 10'h040}));
    next_cmd(20, dt, cmd);
    check("s4_second", 64'({dt[7:0], cmd, req_ready, Addr_Column}),
          64'({8'd4, 5'b00001, 2'b10, 10'h041}));
    next_cmd(20, dt, cmd);
    check("s4_third", 64'({dt[7:0], cmd, req_ready}), 64'({8'd4, 5'b00001, 2'b01}));
    check("s4_cycle", 64'(cyc), 64'(30));
    req_valid = 2'b00;

    // Scenario 5: refresh pending from cycle TREFI -> PRE next cycle, REF +3,
    // then TRFC quiet cycles and ACT via IDLE.
    next_cmd(200, dt, cmd);
    check("s5_pre", 64'({cmd, A_10}), 64'({5'b01000, 1'b1}));
    check("s5_pre_cycle", 64'(cyc), 64'(TREFI + 1));
    req_valid = 2'b01; req_write = 2'b01;
    req_bank  = {3'd0, 3'd1}; req_row = {15'd0, 15'd7}; req_col = {10'h000, 10'h055};
    next_cmd(20, dt, cmd);
    check("s5_ref", 64'({dt[7:0], cmd}), 64'({8'd3, 5'b00100}));
    next_cmd(40, dt, cmd);
    check("s5_act", 64'({dt[7:0], cmd, Addr_Row, BA_in}),
          64'({8'(TRFC + 1), 5'b10000, 15'd7, 3'd1}));

    // Scenario 6: reset in ACT_WAIT, then the held request restarts with ACT.
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("s6_reset", 64'(outs()), 64'(38'd0));
    next_cmd(20, dt, cmd);
    check("s6_act", 64'({dt[7:0], cmd, Addr_Row, busy}), 64'({8'd1, 5'b10000, 15'd7, 1'b1}));
    next_cmd(20, dt, cmd);
    check("s6_write", 64'({dt[7:0], cmd, req_ready, Addr_Column, A_12}),
          64'({8'd3, 5'b00010, 2'b01, 10'h055, 1'b1}));
    req_valid = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_cmd_scheduler.md
DDR3_CMD_SCHEDULER -- requirements
Module: ddr3_cmd_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- tRCD, 3: cycles from ACT to first READ/WRITE.
- tRP, 3: cycles from PRE to next ACT or REF.
- tRFC, 10: cycles from REF to next command.
- tREFI, 100: refresh interval in cycles.
- tCCD, 4: minimum cycles between column commands.
REQ-002 Ports (name, direction, width, meaning), one per line:
- CLK, in, 1: sole clock, rising edge.
- RESET, in, 1: synchronous, active-high.
- req_valid, in, 2: per-requester request valid.
- req_write, in, 2: per-requester 1 = write, 0 = read.
- req_bank, in, 6: {r1[2:0], r0[2:0]} bank.
- req_row, in, 30: {r1[14:0], r0[14:0]} row.
- req_col, in, 20: {r1[9:0], r0[9:0]} column.
- req_ready, out, 2: one-cycle accept strobe per requester.
- ACT, PRE, REF, WRITE, READ, out, 1 each: one-cycle command pulses to the command state machine.
- Addr_Row, out, 15: row for ACT.
- Addr_Column, out, 10: column for READ/WRITE.
- BA_in, out, 3: bank for ACT, READ and WRITE.
- A_10, out, 1: auto-precharge / all-banks flag.
- A_12, out, 1: burst length select.
- busy, out, 1: high whenever state != IDLE.

Function
REQ-003 Registered outputs only; at most one of ACT, PRE, REF, WRITE and READ is high in any cycle.
REQ-004 States: IDLE, ACTIVATE, ACT_WAIT, OPEN, PRECHARGE, PRE_WAIT, REFRESH, REF_WAIT.
REQ-005 Refresh timer:
- Counts 0 to tREFI-1, then wraps to 0.
- Sets ref_pending on wrap.
- ref_pending clears when the REF pulse is issued.
REQ-006 Arbitration: round-robin between requesters 0 and 1; the last-served requester has lower priority; requester 0 wins the first arbitration after reset.
REQ-007 ref_pending beats any request at every decision point (IDLE, OPEN).
REQ-008 IDLE:
- If ref_pending: go to REFRESH.
- Else if any req_valid: latch the winner and go to ACTIVATE.
REQ-009 ACTIVATE: ACT=1 with Addr_Row and BA_in of the winner for one cycle; record open_bank and open_row; go to ACT_WAIT.
REQ-010 ACT_WAIT: hold tRCD-1 cycles, then go to OPEN, so the column command falls exactly tRCD cycles after ACT.
REQ-011 OPEN, no ref_pending, granted request that hits (bank and row equal open_bank and open_row):
- Pulse WRITE or READ per req_write.
- Drive Addr_Column and BA_in; A_10=0; A_12=1.
- req_ready[i]=1 in the same cycle.
- Stay in OPEN and re-arbitrate.
REQ-012 Column commands are spaced at least tCCD cycles apart; a hit arriving earlier is held off without asserting req_ready.
REQ-013 OPEN with a miss, or with ref_pending: go to PRECHARGE.
REQ-014 OPEN with no valid request and no ref_pending: remain in OPEN with the row kept open.
REQ-015 PRECHARGE: PRE=1 with A_10=1 (all banks); clear the open flag; go to PRE_WAIT.
REQ-016 PRE_WAIT lasts tRP cycles from the PRE pulse, then:
- If ref_pending: go to REFRESH.
- Else if a miss request is pending: go to ACTIVATE with the new row.
- Else: go to IDLE.
REQ-017 REFRESH: REF=1 for one cycle; go to REF_WAIT.
REQ-018 REF_WAIT lasts tRFC cycles from the REF pulse, then:
- If ref_pending (re-asserted): go to REFRESH.
- Else: go to IDLE.
REQ-019 Requesters hold req_valid and their fields stable until req_ready; a request whose req_valid drops before service is discarded without a strobe.
REQ-020 Simultaneous events:
- Both requesters valid: served alternately.
- Timer wrap in the same cycle as a column issue: that column command completes; PRE follows in the next cycle.
REQ-021 Counters are sized to the largest parameter; no wrap occurs within a wait state.

Reset
REQ-022 RESET=1 at a rising edge forces, the next cycle:
- state=IDLE; all command pulses, req_ready and busy = 0.
- Addr_Row=0, Addr_Column=0, BA_in=0, A_10=0, A_12=0.
- Refresh timer = 0; ref_pending = 0; open flag = 0; round-robin pointer selects requester 0.
REQ-023 RESET overrides any state, including in the middle of a wait; no command pulse is emitted in the cycle after RESET.

Verification
REQ-024 Scenario 1: r0 write, bank 2, row 0x0005, col 0x010, valid at cycle 0 from IDLE -> ACT at cycle 1 (Addr_Row=0x0005, BA_in=2); WRITE and req_ready[0] at cycle 4 with Addr_Column=0x010.
REQ-025 Scenario 2: r0 read at the same row immediately after Scenario 1 -> READ exactly tCCD=4 cycles after WRITE; no PRE or ACT.
REQ-026 Scenario 3: r1 read at row 0x0006 while row 0x0005 is open -> PRE (A_10=1); ACT 3 cycles later with row 0x0006; READ 3 cycles after that.
REQ-027 Scenario 4: both requesters continuously valid with hits -> req_ready alternates 01, 10, 01 across column commands.
REQ-028 Scenario 5: run 100 cycles with a row open -> PRE, then REF 3 cycles later, no command for 10 cycles, then ACT for the pending request.
REQ-029 Scenario 6: RESET asserted during ACT_WAIT -> next cycle busy=0 and no READ/WRITE pulse; a request re-presented after reset is serviced starting with ACT.
